// File: rtl/sr_pkg.sv
// Shared types and defaults for the SR debounce controller.
package sr_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } ch_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sr_debounce_ch.sv
// One button channel: 2-flop synchronizer, saturating debounce counter and
// a one-cycle accept strobe on each accepted rising edge of the debounced level.
module sr_debounce_ch
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic accept_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_q, accept_d;
  ch_state_e     state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      cnt_q    <= '0;
      accept_q <= 1'b0;
      state_q  <= STABLE;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    db_d     = db_q;
    accept_d = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync2_q != db_q) begin
          state_d = COUNT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (sync2_q == db_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Acceptance: the strobe is registered alongside the new level.
          state_d  = STABLE;
          cnt_d    = '0;
          db_d     = sync2_q;
          accept_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign accept_o = accept_q;

endmodule

// File: rtl/sr_debounce_ctrl.sv
// Debounces set/reset buttons into one-cycle s/r pulses for an external SR
// latch, suppresses simultaneous requests and tracks the latch state.
module sr_debounce_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic q_track,
  output logic conflict
);

  logic set_acc, rst_acc;
  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;
  logic q_q, q_d;

  sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (set_btn),
    .accept_o (set_acc)
  );

  sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_ch (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (rst_btn),
    .accept_o (rst_acc)
  );

  always_comb begin
    s_d        = set_acc & ~rst_acc;
    r_d        = rst_acc & ~set_acc;
    conflict_d = set_acc & rst_acc;
    q_d        = q_q;
    // q follows the pulse in the same cycle; a conflict leaves it untouched.
    if (s_d) begin
      q_d = 1'b1;
    end else if (r_d) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      q_q        <= q_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign q_track  = q_q;

endmodule

// File: tb/tb_sr_debounce_ctrl.sv
// Directed bench for sr_debounce_ctrl with DEBOUNCE_CYCLES=4.
module tb_sr_debounce_ctrl;

  localparam int DC  = 4;
  // Ticks from driving a clean edge (just after edge k) to s visible:
  // first sampled at k+1, pulse after edge k+1+DC+2.
  localparam int LAT = DC + 3;

  logic clk = 1'b0;
  logic rst_n;
  logic set_btn;
  logic rst_btn;
  logic s, r, q_track, conflict;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sr_debounce_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_btn  (set_btn),
    .rst_btn  (rst_btn),
    .s        (s),
    .r        (r),
    .q_track  (q_track),
    .conflict (conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic es, input logic er,
                         input logic ec, input logic eq);
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_conflict"}, 32'(conflict), 32'(ec));
    check({tag, "_q"}, 32'(q_track), 32'(eq));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Press the given buttons for hold ticks, then release and settle.
  task automatic press_chk(input string tag, input logic sv, input logic rv,
                           input int hold, input logic q0);
    logic eq;
    eq = q0;
    set_btn = sv;
    rst_btn = rv;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (i == LAT) begin
        if (sv && !rv) eq = 1'b1;
        else if (rv && !sv) eq = 1'b0;
      end
      chk_out(tag, (i == LAT) && sv && !rv, (i == LAT) && rv && !sv,
              (i == LAT) && sv && rv, eq);
    end
    set_btn = 1'b0;
    rst_btn = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_out({tag, "_rel"}, 1'b0, 1'b0, 1'b0, eq);
    end
  endtask

  initial begin
    logic bounce_pat [16];
    set_btn = 1'b0;
    rst_btn = 1'b0;
    rst_n   = 1'b1;
    #2;
    do_reset();

    // Clean press held long: exactly one s pulse, q set.
    press_chk("clean", 1'b1, 1'b0, 20, 1'b0);

    // Bounce shorter than the debounce window never gets accepted.
    do_reset();
    bounce_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      set_btn = bounce_pat[i];
      tick();
      chk_out("bounce", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("bounce_tail", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Set then reset.
    do_reset();
    press_chk("set", 1'b1, 1'b0, 10, 1'b0);
    press_chk("rst", 1'b0, 1'b1, 10, 1'b1);

    // Simultaneous press with q=1 and with q=0: conflict only, q holds.
    press_chk("set2", 1'b1, 1'b0, 10, 1'b0);
    press_chk("both_q1", 1'b1, 1'b1, 10, 1'b1);
    press_chk("rst2", 1'b0, 1'b1, 10, 1'b1);
    press_chk("both_q0", 1'b1, 1'b1, 10, 1'b0);

    // Reset mid-count with q previously 1; the held button is a fresh press.
    press_chk("set3", 1'b1, 1'b0, 10, 1'b0);
    set_btn = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_out("rmc_assert", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rmc_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_out("rmc_post", i == LAT, 1'b0, 1'b0, i >= LAT);
    end
    set_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("rmc_rel", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sr_debounce_ctrl.md
SR_DEBOUNCE_CTRL -- requirements
Module: sr_debounce_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive synchronized clocks a raw input must hold a new level before it is accepted; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port set_btn, input, 1 bit: raw, asynchronous, bouncy set request.
REQ-005 The block SHALL have port rst_btn, input, 1 bit: raw, asynchronous, bouncy reset request.
REQ-006 The block SHALL have port s, output, 1 bit: one-cycle set pulse for the downstream SR latch.
REQ-007 The block SHALL have port r, output, 1 bit: one-cycle reset pulse for the downstream SR latch.
REQ-008 The block SHALL have port q_track, output, 1 bit: registered copy of the state the downstream latch holds.
REQ-009 The block SHALL have port conflict, output, 1 bit: one-cycle flag for simultaneous accepted set and reset.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer; the debounce logic sees only the second flop.
REQ-011 Each channel SHALL keep debounced level db, counter cnt (width clog2(DEBOUNCE_CYCLES)) and a state machine with states STABLE and COUNT.
REQ-012 In STABLE with sync==db: stay, cnt=0; with sync!=db: go to COUNT, cnt=1.
REQ-013 In COUNT with sync==db (bounce back): return to STABLE, cnt=0, db unchanged.
REQ-014 In COUNT with sync!=db and cnt==DEBOUNCE_CYCLES-1: db<=sync, cnt<=0, go to STABLE; otherwise cnt<=cnt+1.
REQ-015 The counter SHALL never wrap; a held mismatch saturates into acceptance per REQ-014.
REQ-016 A channel SHALL raise an internal accept strobe for exactly one cycle on each 0->1 transition of db; 1->0 transitions produce no strobe.
REQ-017 Outputs s, r and conflict SHALL be registered: s = set strobe AND NOT reset strobe; r = reset strobe AND NOT set strobe; conflict = both strobes.
REQ-018 s and r SHALL never be high in the same cycle; on conflict neither SHALL pulse and q_track SHALL hold.
REQ-019 q_track SHALL be set to 1 in the cycle s is high and cleared to 0 in the cycle r is high.
REQ-020 Latency: a clean raw rising edge first sampled at clock edge N SHALL produce s (or r) high for exactly the cycle following edge N+DEBOUNCE_CYCLES+2.
REQ-021 A button held high indefinitely SHALL produce exactly one pulse; a further pulse requires an accepted release and a new accepted press.
REQ-022 Raw glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and leave db unchanged.

Reset
REQ-023 Assertion of rst_n low SHALL immediately force s=0, r=0, conflict=0, q_track=0, all synchronizer flops 0, db=0, cnt=0, state=STABLE.
REQ-024 Reset asserted mid-count SHALL discard the count; after release a button still held SHALL be treated as a new press with full REQ-020 latency.
REQ-025 Reset release SHALL be synchronous to clk externally; the block adds no release synchronizer.

Structure
REQ-026 Package sr_pkg SHALL hold the channel state enum (STABLE, COUNT) and the default DEBOUNCE_CYCLES constant.
REQ-027 One sub-module sr_debounce_ch SHALL implement synchronizer, counter, state machine and strobe for one channel; the top instantiates it twice and adds arbitration and q_track.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: set_btn 0->1 sampled at edge 10, held 20 cycles -> s high only after edge 16, q_track=1 from edge 16, no further s.
REQ-029 Bounce: set_btn high for 3 cycles, low 1, high 2, low -> s never asserts, q_track stays 0.
REQ-030 Set then reset: accepted set, release, then rst_btn press -> s pulse, q_track=1, then single r pulse, q_track=0.
REQ-031 Simultaneous press: set_btn and rst_btn rise at the same edge -> conflict high for 1 cycle, s=r=0, q_track unchanged.
REQ-032 Reset mid-count: rst_n low 2 edges after set_btn rises, released 3 cycles later with set_btn held -> all outputs 0 during reset, s pulses 6 edges after first post-release sampling edge.
